// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: owner-state encoding and default sizes.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_DBG  = 2'd2,
    ST_DUMP = 2'd3
  } owner_e;

  localparam int MAX_CPU_RUN_DEF = 4;
  localparam int AW_DEF          = 32;

endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU, debug-loader and memory-side signals of the data-memory arbiter, bundled as one interface.
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF
);

  logic          cpu_en;
  logic          cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [AW-1:0] cpu_wdata;
  logic [AW-1:0] cpu_rdata;
  logic          cpu_stall;

  logic          dbg_req;
  logic          dbg_wr;
  logic [AW-1:0] dbg_addr;
  logic [AW-1:0] dbg_wdata;
  logic          dbg_gnt;
  logic          dbg_rvalid;
  logic [AW-1:0] dbg_rdata;

  logic          mem_en;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [AW-1:0] mem_wdata;
  logic [AW-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  cpu_en, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dbg_req, dbg_wr, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_en, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Requesters and memory side
  modport master (
    output cpu_en, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dbg_req, dbg_wr, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU and the debug loader, with bounded CPU runs under
// debug contention and an absorbing dump state once the processor halts.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_CPU_RUN = MAX_CPU_RUN_DEF,
  parameter int AW          = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          halt,
  output logic          mem_dump,
  dmem_arbiter_if.slave bus
);

  localparam int            CW      = $clog2(MAX_CPU_RUN + 1);
  localparam logic [CW-1:0] RUN_MAX = CW'(MAX_CPU_RUN);

  owner_e        state_q, state_d;
  logic [CW-1:0] run_cnt_q, run_cnt_d;
  logic          dbg_rvalid_q, dbg_rvalid_d;
  logic [AW-1:0] dbg_rdata_q, dbg_rdata_d;
  logic          mem_dump_q, mem_dump_d;
  logic          dbg_gnt;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      run_cnt_q    <= '0;
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= '0;
      mem_dump_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_cnt_q    <= run_cnt_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      dbg_rdata_q  <= dbg_rdata_d;
      mem_dump_q   <= mem_dump_d;
    end
  end

  // Next-state: the run length is judged on the count including this cycle, so the
  // debug port wins right after the MAX_CPU_RUN-th contended CPU cycle.
  always_comb begin
    run_cnt_d = run_cnt_q;
    if (state_q == ST_DBG || !bus.dbg_req) begin
      run_cnt_d = '0;
    end else if (state_q == ST_CPU && bus.cpu_en && run_cnt_q != RUN_MAX) begin
      run_cnt_d = run_cnt_q + 1'b1;
    end

    state_d = ST_IDLE;
    if (state_q == ST_DUMP || halt) begin
      state_d = ST_DUMP;
    end else if (bus.dbg_req && (!bus.cpu_en || run_cnt_d == RUN_MAX)) begin
      state_d = ST_DBG;
    end else if (bus.cpu_en) begin
      state_d = ST_CPU;
    end else if (bus.dbg_req) begin
      state_d = ST_DBG;
    end

    mem_dump_d = (state_d == ST_DUMP) && (state_q != ST_DUMP);
  end

  // Outputs: memory port muxed from the registered owner only
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.cpu_rdata = '0;
    bus.cpu_stall = bus.cpu_en;
    dbg_gnt       = 1'b0;
    unique case (state_q)
      ST_CPU: begin
        bus.mem_en    = bus.cpu_en;
        bus.mem_wr    = bus.cpu_wr;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        bus.cpu_rdata = bus.mem_rdata;
        bus.cpu_stall = 1'b0;
      end
      ST_DBG: begin
        bus.mem_en    = bus.dbg_req;
        bus.mem_wr    = bus.dbg_wr;
        bus.mem_addr  = bus.dbg_addr;
        bus.mem_wdata = bus.dbg_wdata;
        dbg_gnt       = bus.dbg_req;
      end
      default: ;
    endcase
  end

  // Read-return capture runs off the grant alone, so a halt arriving mid-read still delivers it
  always_comb begin
    dbg_rvalid_d = dbg_gnt && !bus.dbg_wr;
    dbg_rdata_d  = dbg_rvalid_d ? bus.mem_rdata : dbg_rdata_q;
  end

  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.dbg_rvalid = dbg_rvalid_q;
  assign bus.dbg_rdata  = dbg_rdata_q;
  assign mem_dump       = mem_dump_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: CPU-only, contention, debug load, halt/dump and async reset.
module tb_dmem_arbiter;

  logic clk;
  logic rst;
  logic halt;
  logic mem_dump;
  int   n_tests;
  int   n_fail;

  logic [31:0] mem [64];

  dmem_arbiter_if #(.AW(32)) bus ();

  dmem_arbiter #(.MAX_CPU_RUN(4), .AW(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .halt     (halt),
    .mem_dump (mem_dump),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational-read memory; address 0x10 is preloaded on reset
  assign bus.mem_rdata = mem[bus.mem_addr[5:0]];
  always @(posedge clk or negedge rst) begin
    if (!rst) mem[16] <= 32'hDEADBEEF;
    else if (bus.mem_en && bus.mem_wr) mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    halt = 1'b0;
    bus.cpu_en = 1'b1;
    bus.cpu_wr = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_wdata = '0;
    bus.dbg_req = 1'b0;
    bus.dbg_wr = 1'b0;
    bus.dbg_addr = '0;
    bus.dbg_wdata = '0;

    // Reset state
    #2;
    check("rst_mem_en", 32'(bus.mem_en), 32'd0);
    check("rst_stall", 32'(bus.cpu_stall), 32'd1);
    check("rst_gnt", 32'(bus.dbg_gnt), 32'd0);
    check("rst_rvalid", 32'(bus.dbg_rvalid), 32'd0);
    check("rst_rdata", bus.dbg_rdata, 32'd0);
    check("rst_dump", 32'(mem_dump), 32'd0);
    check("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
    bus.cpu_en = 1'b0;
    #8;
    rst = 1'b1;

    // CPU-only read of 0x10
    cyc();
    bus.cpu_en = 1'b1;
    bus.cpu_addr = 32'h10;
    settle();
    check("cpu_first_stall", 32'(bus.cpu_stall), 32'd1);
    check("cpu_first_mem_en", 32'(bus.mem_en), 32'd0);
    cyc();
    settle();
    check("cpu_rdata", bus.cpu_rdata, 32'hDEADBEEF);
    check("cpu_stall", 32'(bus.cpu_stall), 32'd0);
    check("cpu_mem_en", 32'(bus.mem_en), 32'd1);
    check("cpu_mem_addr", bus.mem_addr, 32'h10);
    cyc();
    bus.cpu_en = 1'b0;
    settle();

    // Contention: both rise together from IDLE, CPU first, then 4 CPU : 1 DBG
    cyc();
    bus.cpu_en = 1'b1;
    bus.dbg_req = 1'b1;
    bus.dbg_wr = 1'b0;
    bus.dbg_addr = 32'h10;
    settle();
    check("cont_idle_stall", 32'(bus.cpu_stall), 32'd1);
    check("cont_idle_gnt", 32'(bus.dbg_gnt), 32'd0);
    for (int i = 1; i <= 10; i++) begin
      cyc();
      settle();
      check($sformatf("cont_gnt_%0d", i), 32'(bus.dbg_gnt), (i % 5 == 0) ? 32'd1 : 32'd0);
      check($sformatf("cont_stall_%0d", i), 32'(bus.cpu_stall), (i % 5 == 0) ? 32'd1 : 32'd0);
      check($sformatf("cont_rvalid_%0d", i), 32'(bus.dbg_rvalid),
            (i % 5 == 1 && i > 1) ? 32'd1 : 32'd0);
      if (i == 6) check("cont_rdata", bus.dbg_rdata, 32'hDEADBEEF);
    end
    cyc();
    bus.cpu_en = 1'b0;
    bus.dbg_req = 1'b0;
    settle();
    check("cont_rvalid_11", 32'(bus.dbg_rvalid), 32'd1);

    // Debug load: four writes then a read-back of 0x2
    cyc();
    bus.dbg_req = 1'b1;
    bus.dbg_wr = 1'b1;
    bus.dbg_addr = 32'h0;
    bus.dbg_wdata = 32'h11110000;
    settle();
    check("load_idle_gnt", 32'(bus.dbg_gnt), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      bus.dbg_addr = 32'(i);
      bus.dbg_wdata = 32'h11110000 + 32'(i);
      settle();
      check($sformatf("load_wr_gnt_%0d", i), 32'(bus.dbg_gnt), 32'd1);
      check($sformatf("load_wr_stall_%0d", i), 32'(bus.cpu_stall), 32'd0);
    end
    cyc();
    bus.dbg_wr = 1'b0;
    bus.dbg_addr = 32'h2;
    settle();
    check("load_rd_gnt", 32'(bus.dbg_gnt), 32'd1);
    check("load_rd_rvalid_early", 32'(bus.dbg_rvalid), 32'd0);
    cyc();
    bus.dbg_req = 1'b0;
    settle();
    check("load_rvalid", 32'(bus.dbg_rvalid), 32'd1);
    check("load_rdata", bus.dbg_rdata, 32'h11110002);
    check("load_gnt_off", 32'(bus.dbg_gnt), 32'd0);
    cyc();
    settle();
    check("load_rvalid_drop", 32'(bus.dbg_rvalid), 32'd0);
    check("load_rdata_hold", bus.dbg_rdata, 32'h11110002);

    // Halt right after a granted read
    bus.dbg_req = 1'b1;
    bus.dbg_addr = 32'h1;
    cyc();
    settle();
    check("halt_rd_gnt", 32'(bus.dbg_gnt), 32'd1);
    cyc();
    halt = 1'b1;
    bus.dbg_req = 1'b0;
    settle();
    check("halt_rvalid", 32'(bus.dbg_rvalid), 32'd1);
    check("halt_rdata", bus.dbg_rdata, 32'h11110001);
    check("halt_dump_early", 32'(mem_dump), 32'd0);
    cyc();
    halt = 1'b0;
    bus.cpu_en = 1'b1;
    bus.dbg_req = 1'b1;
    settle();
    check("dump_pulse", 32'(mem_dump), 32'd1);
    check("dump_gnt", 32'(bus.dbg_gnt), 32'd0);
    check("dump_mem_en", 32'(bus.mem_en), 32'd0);
    check("dump_stall", 32'(bus.cpu_stall), 32'd1);
    for (int i = 0; i < 2; i++) begin
      cyc();
      settle();
      check($sformatf("dump_hold_pulse_%0d", i), 32'(mem_dump), 32'd0);
      check($sformatf("dump_hold_gnt_%0d", i), 32'(bus.dbg_gnt), 32'd0);
      check($sformatf("dump_hold_mem_en_%0d", i), 32'(bus.mem_en), 32'd0);
    end

    // Reset out of DUMP, then reset again in the middle of a debug read
    #2 rst = 1'b0;
    bus.cpu_en = 1'b0;
    bus.dbg_addr = 32'h3;
    #2 rst = 1'b1;
    cyc();
    settle();
    check("rerun_gnt", 32'(bus.dbg_gnt), 32'd1);
    cyc();
    settle();
    check("mid_rvalid_pre", 32'(bus.dbg_rvalid), 32'd1);
    check("mid_mem_en_pre", 32'(bus.mem_en), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_mem_en", 32'(bus.mem_en), 32'd0);
    check("mid_rst_rvalid", 32'(bus.dbg_rvalid), 32'd0);
    check("mid_rst_gnt", 32'(bus.dbg_gnt), 32'd0);
    check("mid_rst_rdata", bus.dbg_rdata, 32'd0);
    #1 rst = 1'b1;
    #1;
    check("post_rst_idle_gnt", 32'(bus.dbg_gnt), 32'd0);
    check("post_rst_idle_mem_en", 32'(bus.mem_en), 32'd0);
    cyc();
    settle();
    check("post_rst_gnt", 32'(bus.dbg_gnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
